// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store APB requester.
package lsu_pkg;

    // RISC-V load/store width encodings (funct3)
    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } lsu_state_e;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    localparam int LSU_TIMEOUT_CYC_DEF = 16;

    // A request is legal when its width exists for its direction and is naturally aligned.
    function automatic logic req_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3)
            LSU_B:   ok = 1'b1;
            LSU_H:   ok = !a[0];
            LSU_W:   ok = (a == 2'b00);
            LSU_BU:  ok = !we;
            LSU_HU:  ok = !we && !a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte strobes for a store of the given width at lane offset a.
    function automatic logic [3:0] strb_for(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        case (f3[1:0])
            2'b00:   s = STRB_B << a;
            2'b01:   s = STRB_H << a;
            default: s = STRB_W;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lsu_ld_ext.sv
// Read-data lane alignment and sign/zero extension for loads.
module lsu_ld_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [31:0] lane;

    assign lane = rdata >> {addr_lo, 3'b000};

    // Pick the addressed byte/half and extend it to 32 bits.
    always_comb begin
        data = lane;
        case (funct3)
            LSU_B:   data = {{24{lane[7]}}, lane[7:0]};
            LSU_H:   data = {{16{lane[15]}}, lane[15:0]};
            LSU_BU:  data = {24'd0, lane[7:0]};
            LSU_HU:  data = {16'd0, lane[15:0]};
            default: data = lane;
        endcase
    end

endmodule

// File: rtl/lsu_apb_master.sv
// Load/store APB requester: one CPU request at a time, issued as an APB
// SETUP/ACCESS transfer, response returned as a registered one-cycle pulse.
// Optional build macro LSU_APB_TIMEOUT_EN aborts an ACCESS phase after
// TIMEOUT_CYC cycles without pready_i.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | ready for a request; illegal requests answered from here
// ST_SETUP  | APB setup phase (psel=1, penable=0)
// ST_ACCESS | APB access phase, waits for pready_i (or timeout)
module lsu_apb_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_CYC_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_we_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [2:0]        req_funct3_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [31:0]       pwdata_o,
    output logic [3:0]        pstrb_o,
    input  logic [31:0]       prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    lsu_state_e        state_q, state_d;
    logic              accept, legal;
    logic [2:0]        funct3_q;
    logic [1:0]        addr_lo_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [31:0]       pwdata_q;
    logic [3:0]        pstrb_q;
    logic              psel_q, penable_q;
    logic              rsp_valid_q, rsp_err_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_valid_d, rsp_err_d;
    logic [31:0]       rsp_rdata_d;
    logic [31:0]       ld_data;
    logic              tmo_hit;

    assign accept = req_valid_i && (state_q == ST_IDLE);
    assign legal  = req_legal(req_we_i, req_funct3_i, req_addr_i[1:0]);

`ifdef LSU_APB_TIMEOUT_EN
    // Down-counter loaded in SETUP so that it reaches zero on the last allowed ACCESS cycle.
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt_q;

    // Wait-state timer for the ACCESS phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            tmo_cnt_q <= TMO_LOAD;
        end else if (state_q == ST_ACCESS && !pready_i && tmo_cnt_q != '0) begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt_q == '0);
`else
    assign tmo_hit = 1'b0;
`endif

    lsu_ld_ext u_ld_ext (
        .rdata   (prdata_i),
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .data    (ld_data)
    );

    // Next-state and next-response decode.
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (legal) begin
                        state_d = ST_SETUP;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr_i;
                    if (!pslverr_i && !pwrite_q) begin
                        rsp_rdata_d = ld_data;
                    end
                end else if (tmo_hit) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // APB control and CPU response registers, decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            psel_q      <= (state_d != ST_IDLE);
            penable_q   <= (state_d == ST_ACCESS);
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Request capture; only legal requests disturb the APB payload, which then holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
        end else if (accept && legal) begin
            paddr_q   <= {req_addr_i[ADDR_W-1:2], 2'b00};
            pwrite_q  <= req_we_i;
            pwdata_q  <= req_wdata_i << {req_addr_i[1:0], 3'b000};
            pstrb_q   <= req_we_i ? strb_for(req_funct3_i, req_addr_i[1:0]) : 4'b0000;
            funct3_q  <= req_funct3_i;
            addr_lo_q <= req_addr_i[1:0];
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign paddr_o     = paddr_q;
    assign pwrite_o    = pwrite_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = pstrb_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: doc/lsu_apb_master.md
# lsu_apb_master

APB requester on the load/store path: accepts one CPU load/store request at a time, issues it as an APB SETUP/ACCESS transfer to the data-memory bank, then returns aligned, sign/zero-extended read data or a completion status. It sits between the execute stage and the data-memory completer. It owns byte-lane steering, strobe generation, misalignment checks and wait-state handling.

## Interface
- ADDR_W, 32: CPU/APB byte-address width
- TIMEOUT_CYC, 16: ACCESS cycles without pready before abort (only with timeout feature)

- clk_i  in  1  clock; one clock, all logic on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  CPU request valid
- req_ready_o  out  1  block can accept a request
- req_addr_i  in  ADDR_W  byte address
- req_we_i  in  1  1 = store, 0 = load
- req_wdata_i  in  32  store data, LSB-justified
- req_funct3_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned, illegal funct3, pslverr or timeout
- paddr_o  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}
- psel_o / penable_o / pwrite_o  out  1 each  APB control
- pwdata_o  out  32  lane-steered store data
- pstrb_o  out  4  byte strobes; 0000 on reads
- prdata_i  in  32  completer read data
- pready_i / pslverr_i  in  1 each  completer handshake

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- req_ready_o = (state == IDLE).
- Accept on req_valid_i && req_ready_o. Register address, width, sign and data.
- Legality check at accept:
  - Illegal funct3: loads 011/110/111; stores anything but 000/001/010.
  - Misaligned: H with addr[0]=1; W with addr[1:0]≠0.
  - Illegal request: no APB transfer, state stays IDLE, next cycle rsp_valid_o=1 and rsp_err_o=1.
- Legal request: IDLE→SETUP (psel=1, penable=0) → ACCESS (psel=1, penable=1).
  - ACCESS repeats while pready_i=0.
  - On pready_i=1: capture prdata_i and pslverr_i, go to IDLE, next cycle rsp_valid_o=1.
- Strobes: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
- pwdata_o = req_wdata_i << (8*addr[1:0]).
- Read path: prdata_i >> (8*addr[1:0]), then extend:
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: pass through.
- On pslverr_i=1: rsp_err_o=1 and rsp_rdata_o=0.
- paddr_o, pwrite_o, pwdata_o and pstrb_o are stable from SETUP until ACCESS completes, then hold their last value in IDLE.

## Timing
- Reset values: state IDLE; psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o = 0; paddr_o, pwdata_o, pstrb_o, rsp_rdata_o = 0.
- Reset mid-transfer drops psel_o/penable_o immediately (asynchronous). No response is issued.
- Zero-wait-state latency: accept at edge N; SETUP in cycle N+1; ACCESS in cycle N+2; rsp_valid_o in cycle N+3.
- Each pready_i=0 cycle adds one cycle of latency.
- Illegal request: rsp_valid_o in cycle N+1.
- req_ready_o is high in the same cycle as rsp_valid_o, so back-to-back requests are allowed. Throughput is 1 transfer per 3 cycles.
- All outputs are registered. No combinational path from APB inputs to CPU outputs.

## Configuration
- LSU_APB_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments per cycle while pready_i=0.
  - When it reaches TIMEOUT_CYC, psel_o/penable_o drop, state goes to IDLE, and next cycle rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0.
  - If pready_i=1 arrives in the same cycle as the timeout, it completes normally.
- LSU_APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely.

## Structure
- Package lsu_pkg holds:
  - funct3 enum (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU)
  - FSM state enum
  - strobe constants
  - default TIMEOUT_CYC
- One sub-module, lsu_ld_ext: combinational lane shift plus sign/zero extension of read data, keyed by funct3 and addr[1:0].

## Test plan
- SB 0x000000AB to addr 0x103, pready=1 -> SETUP then ACCESS; pstrb=1000, pwdata=0xAB000000, paddr=0x100; rsp_valid 3 cycles after accept, err=0.
- LH addr 0x202, prdata=0x80F10000 -> rsp_rdata=0xFFFF80F1. LHU same -> 0x000080F1.
- LW addr 0x106 -> no psel; rsp_valid+rsp_err next cycle. Store funct3 100 -> same.
- LW with pready low 3 cycles -> penable high 4 cycles, paddr/pwrite stable throughout; pslverr=1 at completion -> rsp_err=1, rdata=0.
- Reset asserted during ACCESS -> psel/penable 0 immediately, no rsp_valid. After release, a new request completes normally.
- With LSU_APB_TIMEOUT_EN, TIMEOUT_CYC=4 and pready stuck low -> abort after 4 ACCESS cycles, rsp_err=1. Without the macro -> still in ACCESS after 100 cycles.
